// File: rtl/cpu_pkg.sv
// Shared encodings for the CPU front end: fetch FSM states and next-PC selects.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;

endpackage

// File: rtl/fetch_imem.sv
// Instruction store: one synchronous write port, one asynchronous read port, no reset.
module fetch_imem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_unit.sv
// Program-load and instruction-fetch front end: load counter, PC sequencing,
// bounds checking and LOAD/RUN/HALT control around the instruction store.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    input  logic              start,
    input  logic [1:0]        pc_sel,
    input  logic [ADDR_W-1:0] branch_off,
    input  logic [ADDR_W-1:0] jump_target,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W:0]   count,
    output logic [1:0]        state,
    output logic              done,
    output logic              err
);

    fetch_state_t      cur;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W-1:0] pc_q;
    logic              done_q;
    logic              err_q;

    logic              in_load;
    logic              xfer;
    logic [ADDR_W:0]   pc_inc;
    logic [ADDR_W:0]   nxt;
    logic              is_seq;
    logic              in_range;

    assign in_load     = (cur != ST_RUN) && (cur != ST_HALT);
    assign load_ready  = in_load && (count_q != (ADDR_W+1)'(DEPTH));
    assign xfer        = load_valid && load_ready;
    assign instr_valid = (cur == ST_RUN);

    assign state = cur;
    assign pc    = pc_q;
    assign count = count_q;
    assign done  = done_q;
    assign err   = err_q;

    fetch_imem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_imem (
        .clk   (clk),
        .we    (xfer && !rst),
        .waddr (count_q[ADDR_W-1:0]),
        .wdata (load_data),
        .raddr (pc_q),
        .rdata (instr)
    );

    // Next PC in ADDR_W+1 two's complement: MSB set means negative or past DEPTH-1,
    // both of which lie outside [0, count).
    always_comb begin
        pc_inc = {1'b0, pc_q} + 1'b1;
        is_seq = 1'b1;
        nxt    = pc_inc;
        case (pc_sel)
            PC_BR: begin
                nxt    = pc_inc + {branch_off[ADDR_W-1], branch_off};
                is_seq = 1'b0;
            end
            PC_JMP: begin
                nxt    = {1'b0, jump_target};
                is_seq = 1'b0;
            end
            default: ;
        endcase
        in_range = !nxt[ADDR_W] && (nxt < count_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur     <= ST_LOAD;
            count_q <= '0;
            pc_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (cur)
                ST_RUN: begin
                    if (in_range) begin
                        pc_q <= nxt[ADDR_W-1:0];
                    end else begin
                        cur <= ST_HALT;
                        if (is_seq) done_q <= 1'b1;
                        else        err_q  <= 1'b1;
                    end
                end
                ST_HALT: begin
                    if (start) begin
                        cur    <= ST_RUN;
                        pc_q   <= '0;
                        done_q <= 1'b0;
                        err_q  <= 1'b0;
                    end
                end
                default: begin
                    if (xfer) count_q <= count_q + 1'b1;
                    // A transfer on the same edge as start counts towards the program.
                    if (start) begin
                        if ((count_q != '0) || xfer) begin
                            cur    <= ST_RUN;
                            pc_q   <= '0;
                            done_q <= 1'b0;
                            err_q  <= 1'b0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
